// File: rtl/decode_hazard_unit_pkg.sv
// decode_hazard_unit_pkg: shared pipeline types and default constants for the decode hazard unit
package decode_hazard_unit_pkg;
  typedef logic [4:0] creg_addr_t;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic valid;
    logic ready;
    creg_addr_t addr;
    word_t data;
  } fwd_ch_t;
  localparam int MDU_LAT_DEF = 8;
  localparam int NFWD_DEF = 3;
endpackage

// File: rtl/decode_hazard_unit_fwd_select.sv
// fwd_select: priority bypass mux for one read port (index 0 youngest); ports addr/rf/fwd in, data/hazard out
module fwd_select
  import decode_hazard_unit_pkg::*;
#(
  parameter int NFWD = NFWD_DEF
) (
  input  creg_addr_t             addr,
  input  word_t                  rf,
  input  fwd_ch_t [NFWD-1:0]     fwd,
  output word_t                  data,
  output logic                   hazard
);
  always_comb begin
    data = rf;
    hazard = 1'b0;
    // walk oldest to youngest so the youngest match is the last assignment
    for (int c = NFWD - 1; c >= 0; c--)
      if (fwd[c].valid && fwd[c].addr == addr) begin
        data = fwd[c].data;
        hazard = ~fwd[c].ready;
      end
    if (addr == '0) begin
      data = '0;
      hazard = 1'b0;
    end
  end
endmodule

// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit: decode operand bypass, load-use/HI-LO hazard detection and decode->execute register
// ports: clk, reset (async high); decode side d_valid/d_ren/d_ra/d_rf/d_mdu_start/d_hilo_read/d_payload;
// fwd channels; e_stall, flush; outputs opnd, stall_d, d_ready, mdu_busy, e_valid/e_opnd/e_payload
module decode_hazard_unit
  import decode_hazard_unit_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NFWD = NFWD_DEF,
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int PAYLOAD_W = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_valid,
  input  logic [NRD-1:0]         d_ren,
  input  creg_addr_t [NRD-1:0]   d_ra,
  input  word_t [NRD-1:0]        d_rf,
  input  logic                   d_mdu_start,
  input  logic                   d_hilo_read,
  input  logic [PAYLOAD_W-1:0]   d_payload,
  input  fwd_ch_t [NFWD-1:0]     fwd,
  input  logic                   e_stall,
  input  logic                   flush,
  output word_t [NRD-1:0]        opnd,
  output logic                   stall_d,
  output logic                   d_ready,
  output logic                   mdu_busy,
  output logic                   e_valid,
  output word_t [NRD-1:0]        e_opnd,
  output logic [PAYLOAD_W-1:0]   e_payload
);
  // keep at least one bit so MDU_LAT=0 still elaborates; it then simply never loads nonzero
  localparam int CW = MDU_LAT > 0 ? $clog2(MDU_LAT + 1) : 1;
  logic [NRD-1:0] hz;
  logic [CW-1:0] cnt;
  logic issue;
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    fwd_select #(.NFWD(NFWD)) u_sel (
      .addr(d_ra[p]),
      .rf(d_rf[p]),
      .fwd(fwd),
      .data(opnd[p]),
      .hazard(hz[p])
    );
  end
  assign mdu_busy = cnt != '0;
  assign stall_d = d_valid & (|(hz & d_ren) | ((d_mdu_start | d_hilo_read) & mdu_busy));
  assign d_ready = ~stall_d & ~e_stall & ~flush;
  assign issue = d_valid & d_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (issue && d_mdu_start) cnt <= CW'(MDU_LAT);
    else if (mdu_busy) cnt <= cnt - CW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      e_valid <= 1'b0;
      e_opnd <= '0;
      e_payload <= '0;
    end else if (flush) e_valid <= 1'b0;
    else if (!e_stall) begin
      e_valid <= d_valid & ~stall_d;
      if (d_valid && !stall_d) begin
        e_opnd <= opnd;
        e_payload <= d_payload;
      end
    end
endmodule

// File: tb/tb_decode_hazard_unit.sv
// tb_decode_hazard_unit: directed and randomized checks of decode_hazard_unit against a behavioural model
module tb_decode_hazard_unit;
  import decode_hazard_unit_pkg::*;
  localparam int NRD = 2, NFWD = 3, LAT = 4, PW = 32;
  logic clk = 1'b0, reset = 1'b0;
  logic d_valid, d_mdu_start, d_hilo_read, e_stall, flush;
  logic [NRD-1:0] d_ren;
  creg_addr_t [NRD-1:0] d_ra;
  word_t [NRD-1:0] d_rf, opnd, e_opnd;
  logic [PW-1:0] d_payload, e_payload;
  fwd_ch_t [NFWD-1:0] fwd;
  logic stall_d, d_ready, mdu_busy, e_valid;
  always #5 clk = ~clk;
  decode_hazard_unit #(.NRD(NRD), .NFWD(NFWD), .MDU_LAT(LAT), .PAYLOAD_W(PW)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_ren(d_ren), .d_ra(d_ra), .d_rf(d_rf),
    .d_mdu_start(d_mdu_start), .d_hilo_read(d_hilo_read), .d_payload(d_payload), .fwd(fwd),
    .e_stall(e_stall), .flush(flush), .opnd(opnd), .stall_d(stall_d), .d_ready(d_ready),
    .mdu_busy(mdu_busy), .e_valid(e_valid), .e_opnd(e_opnd), .e_payload(e_payload)
  );
  int n_chk = 0, n_pass = 0;
  int edge_n = 0, last_mult = -1000;
  bit m_ev;
  word_t m_eop[NRD];
  bit m_known[NRD];
  logic [PW-1:0] m_epl;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic resolve(input int p, output word_t v, output bit h);
    v = d_rf[p];
    h = 1'b0;
    if (d_ra[p] == 5'd0) begin
      v = 32'd0;
      return;
    end
    for (int c = 0; c < NFWD; c++)
      if (fwd[c].valid && fwd[c].addr == d_ra[p]) begin
        v = fwd[c].data;
        h = !fwd[c].ready;
        return;
      end
  endtask
  task automatic clr();
    d_valid = 1'b1; d_ren = '1; d_ra = '0; d_rf = '0; d_mdu_start = 1'b0; d_hilo_read = 1'b0;
    d_payload = '0; fwd = '0; e_stall = 1'b0; flush = 1'b0;
  endtask
  task automatic model_reset();
    m_ev = 1'b0; m_epl = '0; last_mult = -1000;
    for (int p = 0; p < NRD; p++) begin
      m_eop[p] = 32'd0;
      m_known[p] = 1'b1;
    end
  endtask
  task automatic cycle();
    word_t v[NRD];
    bit h[NRD];
    bit any_hz, busy, st, iss;
    #1;
    busy = (edge_n - last_mult) < LAT;
    any_hz = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      resolve(p, v[p], h[p]);
      if (d_ren[p] && h[p]) any_hz = 1'b1;
    end
    st = d_valid && (any_hz || ((d_mdu_start || d_hilo_read) && busy));
    iss = d_valid && !st && !e_stall && !flush;
    check("mdu_busy", mdu_busy, busy);
    check("stall_d", stall_d, st);
    check("d_ready", d_ready, !st && !e_stall && !flush);
    for (int p = 0; p < NRD; p++) if (!h[p]) check($sformatf("opnd%0d", p), opnd[p], v[p]);
    @(posedge clk);
    edge_n++;
    if (iss && d_mdu_start) last_mult = edge_n;
    if (flush) m_ev = 1'b0;
    else if (!e_stall) begin
      m_ev = d_valid && !st;
      if (m_ev) begin
        m_epl = d_payload;
        for (int p = 0; p < NRD; p++) begin
          m_eop[p] = v[p];
          m_known[p] = !h[p];
        end
      end
    end
    #1;
    check("e_valid", e_valid, m_ev);
    check("e_payload", e_payload, m_epl);
    for (int p = 0; p < NRD; p++) if (m_known[p]) check($sformatf("e_opnd%0d", p), e_opnd[p], m_eop[p]);
  endtask
  initial begin
    clr();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_busy", mdu_busy, 1'b0);
    @(posedge clk);
    #1;
    check("rst_ev", e_valid, 1'b0);
    check("rst_eop", e_opnd, '0);
    check("rst_epl", e_payload, '0);
    reset = 1'b0;
    // no hazard: register-file value passes through
    d_ra[0] = 5'd3; d_rf[0] = 32'h11; d_payload = 32'hCAFE;
    cycle();
    check("nohz_eop", e_opnd[0], 32'h11);
    // youngest matching channel wins
    fwd[0] = '{valid: 1'b1, ready: 1'b1, addr: 5'd5, data: 32'hA};
    fwd[1] = '{valid: 1'b1, ready: 1'b1, addr: 5'd5, data: 32'hB};
    d_ra[1] = 5'd5;
    #1 check("prio0", opnd[1], 32'hA);
    fwd[0].valid = 1'b0;
    #1 check("prio1", opnd[1], 32'hB);
    cycle();
    // load-use stall then resolve in the same cycle ready rises
    clr();
    fwd[0] = '{valid: 1'b1, ready: 1'b0, addr: 5'd7, data: 32'h0};
    d_ra[0] = 5'd7;
    cycle();
    check("lu_ev", e_valid, 1'b0);
    fwd[0].ready = 1'b1; fwd[0].data = 32'h55;
    cycle();
    check("lu_eop", e_opnd[0], 32'h55);
    // $zero ignores forwarding and register file
    clr();
    fwd[0] = '{valid: 1'b1, ready: 1'b0, addr: 5'd0, data: 32'hFF};
    d_rf[0] = 32'h99; d_rf[1] = 32'h99;
    cycle();
    // multiply then dependent mfhi, second mult during busy
    clr();
    d_mdu_start = 1'b1;
    cycle();
    d_mdu_start = 1'b0; d_hilo_read = 1'b1;
    repeat (3) cycle();
    d_hilo_read = 1'b0; d_mdu_start = 1'b1;
    cycle();
    d_mdu_start = 1'b0; d_hilo_read = 1'b1;
    #1 check("mfhi_free", stall_d, 1'b0);
    cycle();
    // flush beats e_stall
    clr();
    flush = 1'b1; e_stall = 1'b1;
    cycle();
    check("flush_ev", e_valid, 1'b0);
    // e_stall alone holds the execute slot
    clr();
    d_payload = 32'h1234;
    cycle();
    e_stall = 1'b1; d_payload = 32'h5678;
    cycle();
    check("hold_epl", e_payload, 32'h1234);
    // async reset mid-count
    clr();
    d_mdu_start = 1'b1;
    cycle();
    d_mdu_start = 1'b0;
    cycle();
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_busy", mdu_busy, 1'b0);
    check("arst_ev", e_valid, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    // randomized traffic
    repeat (400) begin
      d_valid = $urandom_range(0, 7) != 0;
      d_ren = NRD'($urandom);
      for (int p = 0; p < NRD; p++) begin
        d_ra[p] = 5'($urandom_range(0, 6));
        d_rf[p] = $urandom;
      end
      for (int c = 0; c < NFWD; c++)
        fwd[c] = '{valid: 1'($urandom), ready: $urandom_range(0, 3) != 0,
                   addr: 5'($urandom_range(0, 6)), data: $urandom};
      d_mdu_start = $urandom_range(0, 7) == 0;
      d_hilo_read = $urandom_range(0, 5) == 0;
      d_payload = $urandom;
      e_stall = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 11) == 0;
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decode_hazard_unit.md
# decode_hazard_unit

Parametrised operand-read, bypass and hazard block for the decode stage of the five-stage MIPS pipeline. It resolves each source operand from a configurable number of forwarding channels (youngest first) or the register file. It detects load-use and HI/LO multi-cycle-divide/multiply hazards via an internal busy counter, and owns the decode→execute pipeline register with stall, bubble and flush control.

## Interface
Parameters:
- NRD, 2, number of source-operand read ports
- NFWD, 3, number of forwarding channels; index 0 is the youngest producer (execute)
- MDU_LAT, 8, cycles HI/LO stay busy after a multiply/divide issues (0 = never busy)
- PAYLOAD_W, 128, width of the opaque decoded-instruction payload carried to execute

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- d_valid  in  1  decode slot holds an instruction
- d_ren  in  NRD  read-port enable per operand
- d_ra  in  NRD×5  source register addresses (creg_addr_t)
- d_rf  in  NRD×32  register-file read data
- d_mdu_start  in  1  decoded instruction starts a multi-cycle mult/div
- d_hilo_read  in  1  decoded instruction reads HI or LO (mfhi/mflo)
- d_payload  in  PAYLOAD_W  remaining decoded fields
- fwd  in  NFWD×fwd_ch_t  {valid, ready, addr, data} per channel
- e_stall  in  1  execute cannot accept
- flush  in  1  kill the instruction entering execute
- opnd  out  NRD×32  resolved operands (combinational, for branch compare in decode)
- stall_d  out  1  decode hazard present
- d_ready  out  1  decode may advance (= ~stall_d & ~e_stall & ~flush)
- mdu_busy  out  1  HI/LO result pending
- e_valid  out  1  execute slot valid (registered)
- e_opnd  out  NRD×32  registered operands
- e_payload  out  PAYLOAD_W  registered payload

## Operation
- Operand resolve per port p: if d_ra[p]==0 → opnd=0. Else the lowest index c with fwd[c].valid & fwd[c].addr==d_ra[p] is selected. If it is ready → opnd=fwd[c].data; if it is not ready → a hazard is raised and opnd is don't-care. If no channel matches → opnd=d_rf[p]. Older matching channels are ignored even if ready.
- Hazard: stall_d = d_valid & (any enabled port hazard | ((d_mdu_start | d_hilo_read) & mdu_busy)). Disabled ports never stall.
- Issue = d_valid & ~stall_d & ~e_stall & ~flush.
- MDU counter cnt (width clog2(MDU_LAT+1)). On an issue with d_mdu_start, cnt is loaded with MDU_LAT. Otherwise, if cnt≠0, it decrements each cycle regardless of e_stall. flush does not cancel a count already loaded. mdu_busy = cnt≠0.
- Register update priority at posedge: reset > flush (e_valid←0) > e_stall (hold all) > stall_d or ~d_valid (bubble: e_valid←0) > capture (e_valid←1, e_opnd←opnd, e_payload←d_payload).
- Reset values: e_valid=0, e_opnd=0, e_payload=0, cnt=0. Combinational outputs follow their inputs.

## Timing
- opnd, stall_d, d_ready: same cycle as inputs, with no internal state except mdu_busy.
- e_*: 1-cycle latency from issue.
- MDU: a multiply issued at edge t gives cnt=MDU_LAT from t; a dependent mfhi stalls and issues at edge t+MDU_LAT+1 at the earliest.
- flush and e_stall in the same cycle: flush wins and e_valid becomes 0.
- A hazard that resolves (fwd ready rises) issues in that same cycle.
- Asynchronous reset mid-count clears cnt immediately; mdu_busy drops without waiting for a clock.

## Structure
- The shared pipeline package holds the fwd_ch_t struct, creg_addr_t and word_t. MDU_LAT and NFWD defaults live as localparam constants there.
- One sub-module, fwd_select: a priority bypass mux for a single read port, with outputs {data, hazard}, instantiated NRD times via generate.
- The MDU counter and the pipeline register stay in the top module.

## Test plan
- No hazard: d_ra[0]=3, d_rf[0]=0x11, no fwd matches → opnd[0]=0x11, stall_d=0; next cycle e_valid=1, e_opnd[0]=0x11.
- Priority: fwd0 {addr 5, 0xA, ready} and fwd1 {addr 5, 0xB, ready}, d_ra[1]=5 → opnd[1]=0xA. With fwd0.valid=0 → opnd[1]=0xB.
- Load-use: fwd0 {addr 7, ready=0}, d_ra[0]=7 → stall_d=1, e_valid=0 next cycle. When ready=1 with data 0x55 → issue, and e_opnd[0]=0x55.
- $zero: d_ra=0, fwd0 {addr 0, 0xFF, ready=0}, d_rf=0x99 → opnd=0, stall_d=0.
- MDU (MDU_LAT=4): a mult issues at edge 0, then an mfhi is presented → stall_d=1 for 4 cycles and the mfhi issues at edge 5. A second mult during busy also stalls.
- Control: flush with e_stall=1 → e_valid=0 next cycle. Asserting reset with cnt=3 → mdu_busy=0 immediately and e_valid=0.
